// File: rtl/el2_dec_nbload_sb_if.sv
// Bundle of the non-blocking load scoreboard's side-band signals:
// allocation from commit, data return and kill from the LSU, decode
// source/destination operands, and the stall / GPR write-back outputs.
interface el2_dec_nbload_sb_if #(
    parameter int TAG_W = 2
) ();
    // allocation of a tag by a committing non-blocking load
    logic             alloc_valid;
    logic [TAG_W-1:0] alloc_tag;
    logic [4:0]       alloc_rd;
    // LSU data return
    logic             ret_valid;
    logic [TAG_W-1:0] ret_tag;
    logic [31:0]      ret_data;
    logic             ret_error;
    // flush cancel of an outstanding tag
    logic             kill_valid;
    logic [TAG_W-1:0] kill_tag;
    // instruction in decode
    logic [4:0]       dec_rs1_addr;
    logic [4:0]       dec_rs2_addr;
    logic             dec_rs1_en;
    logic             dec_rs2_en;
    logic [4:0]       dec_rd_addr;
    logic             dec_rd_en;
    // scoreboard status and GPR load-return write port
    logic             sb_stall;
    logic             sb_full;
    logic             gpr_wen;
    logic [4:0]       gpr_waddr;
    logic [31:0]      gpr_wd;
    logic             sb_err;

    // decode/LSU side: drives requests, observes status and write port
    modport master (
        output alloc_valid, alloc_tag, alloc_rd,
        output ret_valid, ret_tag, ret_data, ret_error,
        output kill_valid, kill_tag,
        output dec_rs1_addr, dec_rs2_addr, dec_rs1_en, dec_rs2_en,
        output dec_rd_addr, dec_rd_en,
        input  sb_stall, sb_full, gpr_wen, gpr_waddr, gpr_wd, sb_err
    );

    // scoreboard side
    modport slave (
        input  alloc_valid, alloc_tag, alloc_rd,
        input  ret_valid, ret_tag, ret_data, ret_error,
        input  kill_valid, kill_tag,
        input  dec_rs1_addr, dec_rs2_addr, dec_rs1_en, dec_rs2_en,
        input  dec_rd_addr, dec_rd_en,
        output sb_stall, sb_full, gpr_wen, gpr_waddr, gpr_wd, sb_err
    );
endinterface

// File: rtl/el2_dec_nbload_sb.sv
// Non-blocking load scoreboard and load-return writeback stage.
// Tracks outstanding load tags with their destination registers, raises
// the decode stall on RAW/WAW hazards against them (including the write
// still sitting in the writeback register), and drives the GPR load-return
// port from a single registered stage.
module el2_dec_nbload_sb #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input logic               clk,
    input logic               rst_l,
    el2_dec_nbload_sb_if.slave sb
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] vld_r;
    logic [4:0]       rd_r [DEPTH];
    logic             wb_vld_r;
    logic [4:0]       wb_rd_r;
    logic [31:0]      wb_data_r;
    logic             err_r;

    logic [DEPTH-1:0] vld_s;
    logic [4:0]       rd_s [DEPTH];
    logic             wb_vld_s;
    logic [4:0]       wb_rd_s;
    logic [31:0]      wb_data_s;
    logic             err_s;

    logic             rs1_hit_s;
    logic             rs2_hit_s;
    logic             rd_hit_s;
    logic             stall_s;

    // Next state: kill, then return, then alloc, each seeing the previous step.
    // The writeback address/data are held at zero whenever no write is pending
    // so the GPR port can be driven straight from the register.
    always_comb begin
        vld_s     = vld_r;
        rd_s      = rd_r;
        wb_vld_s  = 1'b0;
        wb_rd_s   = 5'd0;
        wb_data_s = 32'd0;
        err_s     = err_r;

        if (sb.kill_valid) begin
            vld_s[sb.kill_tag] = 1'b0;
        end else begin
            vld_s = vld_s;
        end

        if (sb.ret_valid) begin
            if (vld_s[sb.ret_tag]) begin
                vld_s[sb.ret_tag] = 1'b0;
                if (!sb.ret_error && (rd_s[sb.ret_tag] != 5'd0)) begin
                    wb_vld_s  = 1'b1;
                    wb_rd_s   = rd_s[sb.ret_tag];
                    wb_data_s = sb.ret_data;
                end else begin
                    wb_vld_s  = 1'b0;
                end
            end else begin
                // return for a tag nobody is waiting on (incl. killed this cycle)
                err_s = 1'b1;
            end
        end else begin
            wb_vld_s = 1'b0;
        end

        if (sb.alloc_valid) begin
            if (vld_s[sb.alloc_tag]) begin
                // tag still live: overwrite, but flag the protocol violation
                err_s = 1'b1;
            end else begin
                err_s = err_s;
            end
            vld_s[sb.alloc_tag] = 1'b1;
            rd_s[sb.alloc_tag]  = sb.alloc_rd;
        end else begin
            vld_s = vld_s;
        end
    end

    // Scoreboard, writeback stage and sticky error register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            vld_r     <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_r[i] <= 5'd0;
            end
            wb_vld_r  <= 1'b0;
            wb_rd_r   <= 5'd0;
            wb_data_r <= 32'd0;
            err_r     <= 1'b0;
        end else begin
            vld_r     <= vld_s;
            rd_r      <= rd_s;
            wb_vld_r  <= wb_vld_s;
            wb_rd_r   <= wb_rd_s;
            wb_data_r <= wb_data_s;
            err_r     <= err_s;
        end
    end

    // Hazard match of the decode operands against live tags and the pending
    // write; x0 is never hazardous since it is never written.
    always_comb begin
        rs1_hit_s = wb_vld_r & (wb_rd_r == sb.dec_rs1_addr);
        rs2_hit_s = wb_vld_r & (wb_rd_r == sb.dec_rs2_addr);
        rd_hit_s  = wb_vld_r & (wb_rd_r == sb.dec_rd_addr);
        for (int i = 0; i < DEPTH; i++) begin
            rs1_hit_s = rs1_hit_s | (vld_r[i] & (rd_r[i] == sb.dec_rs1_addr));
            rs2_hit_s = rs2_hit_s | (vld_r[i] & (rd_r[i] == sb.dec_rs2_addr));
            rd_hit_s  = rd_hit_s  | (vld_r[i] & (rd_r[i] == sb.dec_rd_addr));
        end
        stall_s = (sb.dec_rs1_en & (sb.dec_rs1_addr != 5'd0) & rs1_hit_s) |
                  (sb.dec_rs2_en & (sb.dec_rs2_addr != 5'd0) & rs2_hit_s) |
                  (sb.dec_rd_en  & (sb.dec_rd_addr  != 5'd0) & rd_hit_s);
    end

    // Stall and full are combinational from current state; the GPR port
    // comes directly from the writeback register.
    assign sb.sb_stall  = stall_s;
    assign sb.sb_full   = &vld_r;
    assign sb.gpr_wen   = wb_vld_r;
    assign sb.gpr_waddr = wb_rd_r;
    assign sb.gpr_wd    = wb_data_r;
    assign sb.sb_err    = err_r;

endmodule

// File: tb/tb_el2_dec_nbload_sb.sv
// Self-checking bench for el2_dec_nbload_sb: directed scenarios with
// hand-computed expectations, then randomized traffic, all compared every
// cycle against a behavioural model of the tag table and writeback.
module tb_el2_dec_nbload_sb;

    logic clk;
    logic rst_l;
    int   total;
    int   bad;

    el2_dec_nbload_sb_if #(.TAG_W(2)) bus ();

    el2_dec_nbload_sb #(.DEPTH(4), .TAG_W(2)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .sb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model: set of outstanding loads and the pending write
    bit          m_vld [4];
    logic [4:0]  m_rd  [4];
    bit          m_wbv;
    logic [4:0]  m_wbrd;
    logic [31:0] m_wbd;
    bit          m_err;

    function automatic void model_reset();
        for (int t = 0; t < 4; t++) begin
            m_vld[t] = 1'b0;
            m_rd[t]  = 5'd0;
        end
        m_wbv  = 1'b0;
        m_wbrd = 5'd0;
        m_wbd  = 32'd0;
        m_err  = 1'b0;
    endfunction

    function automatic bit m_match(logic [4:0] a, logic en);
        if (!en || a == 5'd0) return 1'b0;
        for (int t = 0; t < 4; t++) begin
            if (m_vld[t] && m_rd[t] == a) return 1'b1;
        end
        if (m_wbv && m_wbrd == a) return 1'b1;
        return 1'b0;
    endfunction

    // advance the model by one clock using the inputs currently driven
    function automatic void model_step();
        m_wbv  = 1'b0;
        m_wbrd = 5'd0;
        m_wbd  = 32'd0;
        if (bus.kill_valid) m_vld[bus.kill_tag] = 1'b0;
        if (bus.ret_valid) begin
            if (m_vld[bus.ret_tag]) begin
                m_vld[bus.ret_tag] = 1'b0;
                if (!bus.ret_error && m_rd[bus.ret_tag] != 5'd0) begin
                    m_wbv  = 1'b1;
                    m_wbrd = m_rd[bus.ret_tag];
                    m_wbd  = bus.ret_data;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        if (bus.alloc_valid) begin
            if (m_vld[bus.alloc_tag]) m_err = 1'b1;
            m_vld[bus.alloc_tag] = 1'b1;
            m_rd[bus.alloc_tag]  = bus.alloc_rd;
        end
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // compare every DUT output against the model
    task automatic compare_outputs();
        bit st;
        bit full;
        st   = m_match(bus.dec_rs1_addr, bus.dec_rs1_en) |
               m_match(bus.dec_rs2_addr, bus.dec_rs2_en) |
               m_match(bus.dec_rd_addr,  bus.dec_rd_en);
        full = m_vld[0] & m_vld[1] & m_vld[2] & m_vld[3];
        chk("sb_stall",  {31'd0, bus.sb_stall}, {31'd0, st});
        chk("sb_full",   {31'd0, bus.sb_full},  {31'd0, full});
        chk("gpr_wen",   {31'd0, bus.gpr_wen},  {31'd0, m_wbv});
        chk("gpr_waddr", {27'd0, bus.gpr_waddr}, {27'd0, (m_wbv ? m_wbrd : 5'd0)});
        chk("gpr_wd",    bus.gpr_wd, (m_wbv ? m_wbd : 32'd0));
        chk("sb_err",    {31'd0, bus.sb_err},   {31'd0, m_err});
    endtask

    task automatic idle();
        bus.alloc_valid  = 1'b0;
        bus.alloc_tag    = 2'd0;
        bus.alloc_rd     = 5'd0;
        bus.ret_valid    = 1'b0;
        bus.ret_tag      = 2'd0;
        bus.ret_data     = 32'd0;
        bus.ret_error    = 1'b0;
        bus.kill_valid   = 1'b0;
        bus.kill_tag     = 2'd0;
        bus.dec_rs1_addr = 5'd0;
        bus.dec_rs2_addr = 5'd0;
        bus.dec_rs1_en   = 1'b0;
        bus.dec_rs2_en   = 1'b0;
        bus.dec_rd_addr  = 5'd0;
        bus.dec_rd_en    = 1'b0;
    endtask

    // called just after a falling edge with inputs set: check, clock, return
    task automatic tick();
        #1;
        compare_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
        idle();
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        idle();
        model_reset();
        #1;
        compare_outputs();
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    task automatic alloc(logic [1:0] t, logic [4:0] r);
        bus.alloc_valid = 1'b1;
        bus.alloc_tag   = t;
        bus.alloc_rd    = r;
    endtask

    task automatic ret(logic [1:0] t, logic [31:0] d, logic e);
        bus.ret_valid = 1'b1;
        bus.ret_tag   = t;
        bus.ret_data  = d;
        bus.ret_error = e;
    endtask

    task automatic rs1(logic [4:0] a);
        bus.dec_rs1_addr = a;
        bus.dec_rs1_en   = 1'b1;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_l = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        do_reset();
        #1;
        chk("rst_stall", {31'd0, bus.sb_stall}, 32'd0);
        chk("rst_full",  {31'd0, bus.sb_full},  32'd0);
        chk("rst_wen",   {31'd0, bus.gpr_wen},  32'd0);
        chk("rst_waddr", {27'd0, bus.gpr_waddr}, 32'd0);
        chk("rst_wd",    bus.gpr_wd, 32'd0);
        chk("rst_err",   {31'd0, bus.sb_err},   32'd0);

        // RAW on a pending load, release after its write
        alloc(2'd1, 5'd5); tick();
        rs1(5'd5);
        chk("raw_stall", {31'd0, bus.sb_stall}, 32'd1);
        ret(2'd1, 32'hDEADBEEF, 1'b0); tick();
        rs1(5'd5);
        chk("wb_wen",    {31'd0, bus.gpr_wen},  32'd1);
        chk("wb_waddr",  {27'd0, bus.gpr_waddr}, 32'd5);
        chk("wb_wd",     bus.gpr_wd, 32'hDEADBEEF);
        chk("wb_stall",  {31'd0, bus.sb_stall}, 32'd1);
        tick();
        rs1(5'd5);
        chk("rel_stall", {31'd0, bus.sb_stall}, 32'd0);
        chk("rel_wen",   {31'd0, bus.gpr_wen},  32'd0);
        tick();

        // fill all tags, then overwrite a live one
        for (int t = 0; t < 4; t++) begin
            alloc(t[1:0], 5'(t + 1)); tick();
        end
        #1;
        chk("full", {31'd0, bus.sb_full}, 32'd1);
        alloc(2'd2, 5'd20); tick();
        rs1(5'd20);
        chk("ovw_err",   {31'd0, bus.sb_err},   32'd1);
        chk("ovw_new",   {31'd0, bus.sb_stall}, 32'd1);
        rs1(5'd3);
        chk("ovw_old",   {31'd0, bus.sb_stall}, 32'd0);
        tick(); tick();
        #1;
        chk("err_sticky", {31'd0, bus.sb_err}, 32'd1);

        // reset mid-operation, then same-cycle return+alloc of one tag
        do_reset();
        alloc(2'd0, 5'd7); tick();
        ret(2'd0, 32'h1234_5678, 1'b0); alloc(2'd0, 5'd9); tick();
        rs1(5'd9);
        chk("rr_wen",   {31'd0, bus.gpr_wen},  32'd1);
        chk("rr_waddr", {27'd0, bus.gpr_waddr}, 32'd7);
        chk("rr_err",   {31'd0, bus.sb_err},   32'd0);
        chk("rr_x9",    {31'd0, bus.sb_stall}, 32'd1);
        tick();
        rs1(5'd7);
        chk("rr_x7_free", {31'd0, bus.sb_stall}, 32'd0);
        tick();

        // error return frees without a write; kill then return is an error
        alloc(2'd3, 5'd10); tick();
        alloc(2'd2, 5'd11); tick();
        ret(2'd3, 32'hCAFE_F00D, 1'b1); tick();
        rs1(5'd10);
        chk("rerr_wen",   {31'd0, bus.gpr_wen},  32'd0);
        chk("rerr_free",  {31'd0, bus.sb_stall}, 32'd0);
        tick();
        bus.kill_valid = 1'b1; bus.kill_tag = 2'd2; tick();
        ret(2'd2, 32'h5555_AAAA, 1'b0); tick();
        #1;
        chk("kill_wen", {31'd0, bus.gpr_wen}, 32'd0);
        chk("kill_err", {31'd0, bus.sb_err},  32'd1);

        // x0 destination is never a hazard nor a write
        do_reset();
        alloc(2'd1, 5'd0); tick();
        bus.dec_rs1_addr = 5'd0; bus.dec_rs1_en = 1'b1;
        bus.dec_rd_addr  = 5'd0; bus.dec_rd_en  = 1'b1;
        #1;
        chk("x0_stall", {31'd0, bus.sb_stall}, 32'd0);
        ret(2'd1, 32'hFFFF_FFFF, 1'b0); tick();
        #1;
        chk("x0_wen", {31'd0, bus.gpr_wen}, 32'd0);

        // WAW only when rd is actually written
        alloc(2'd0, 5'd6); tick();
        bus.dec_rd_addr = 5'd6; bus.dec_rd_en = 1'b1;
        #1;
        chk("waw_on", {31'd0, bus.sb_stall}, 32'd1);
        bus.dec_rd_en = 1'b0;
        rs1(5'd1);
        chk("waw_off", {31'd0, bus.sb_stall}, 32'd0);
        tick();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            if ($urandom_range(0, 99) < 15) begin
                bus.kill_valid = 1'b1;
                bus.kill_tag   = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 99) < 45) begin
                ret(2'($urandom_range(0, 3)), $urandom(),
                    ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0);
            end
            if ($urandom_range(0, 99) < 45) begin
                alloc(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)));
            end
            bus.dec_rs1_addr = 5'($urandom_range(0, 7));
            bus.dec_rs2_addr = 5'($urandom_range(0, 7));
            bus.dec_rd_addr  = 5'($urandom_range(0, 7));
            bus.dec_rs1_en   = 1'($urandom_range(0, 1));
            bus.dec_rs2_en   = 1'($urandom_range(0, 1));
            bus.dec_rd_en    = 1'($urandom_range(0, 1));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
